dma_write_engine: RTL and testbench

FPGA-side upstream DMA engine that turns host register writes into PCIe Memory Write TLPs. Host writes a 32-bit base address to channel 0, then a TLP count to channel 1. The engine streams that many 128-byte payload TLPs from a 64-bit FPGA-to-host source into host memory starting at base+64. It then writes a 64-bit completion token at base. It sits between the BAR register decoder and the 64-bit Avalon-ST TX port of the PCIe hard IP.

---
 rtl/dma_write_engine.sv | 130 +++++++++++++
 tb/tb_dma_write_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_write_engine.sv
// Upstream DMA: turns host register writes into PCIe MWr TLPs,
// streaming payload QWs then a completion token at the base address.
module dma_write_engine #(
    parameter logic [6:0]  BASE_CHAN   = 7'd0,
    parameter logic [6:0]  CTRL_CHAN   = 7'd1,
    parameter int          PAYLOAD_QWS = 16,
    parameter logic [63:0] TOKEN       = 64'hCAFEF00DC0DEFACE
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [12:0] cfgBusDev_in,
    input  logic [6:0]  cpuChan_in,
    input  logic [31:0] cpuWrData_in,
    input  logic        cpuWrValid_in,
    input  logic [63:0] f2cData_in,
    input  logic        f2cValid_in,
    output logic        f2cReady_out,
    output logic [63:0] tx_data_out,
    output logic        tx_valid_out,
    output logic        tx_sop_out,
    output logic        tx_eop_out,
    input  logic        tx_ready_in,
    output logic        busy_out,
    output logic [31:0] tlpCount_out
);

    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, DATA, TOK0, TOK1, TOKD
    } state_t;

    localparam logic [31:0] PAY_HDR   = 32'h40000000 | 32'(2 * PAYLOAD_QWS);
    localparam logic [31:0] TOK_HDR   = 32'h40000002;
    localparam logic [3:0]  LAST_BEAT = 4'(PAYLOAD_QWS - 1);

    state_t      state, state_n;
    logic [31:0] base, addr, tlp_count;
    logic [7:0]  remaining;
    logic [3:0]  beat;
    logic [15:0] req_id;
    logic        start, xfer, last_beat;

    assign req_id    = {cfgBusDev_in, 3'b000};
    assign start     = (state == IDLE) && cpuWrValid_in &&
                       (cpuChan_in == CTRL_CHAN) && (cpuWrData_in[7:0] != 8'd0);
    assign xfer      = tx_valid_out & tx_ready_in;
    assign last_beat = (state == DATA) && xfer && (beat == LAST_BEAT);

    assign busy_out     = (state != IDLE);
    assign tlpCount_out = tlp_count;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state     <= IDLE;
            base      <= '0;
            addr      <= '0;
            remaining <= '0;
            beat      <= '0;
            tlp_count <= '0;
        end else begin
            state <= state_n;
            // Register writes only land while idle so base/count stay stable mid-DMA
            if (state == IDLE && cpuWrValid_in && cpuChan_in == BASE_CHAN)
                base <= {cpuWrData_in[31:3], 3'b000};
            if (start) begin
                remaining <= cpuWrData_in[7:0];
                addr      <= base + 32'd64;
                beat      <= '0;
            end
            if (state == DATA && xfer)
                beat <= beat + 4'd1;
            if (last_beat) begin
                beat      <= '0;
                tlp_count <= tlp_count + 32'd1;
                remaining <= remaining - 8'd1;
                addr      <= addr + 32'd128;
            end
        end
    end

    always_comb begin
        state_n      = state;
        tx_valid_out = 1'b0;
        tx_sop_out   = 1'b0;
        tx_eop_out   = 1'b0;
        tx_data_out  = '0;
        f2cReady_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = HDR0;
            end
            HDR0: begin
                tx_valid_out = 1'b1;
                tx_sop_out   = 1'b1;
                tx_data_out  = {req_id, 8'h00, 8'hFF, PAY_HDR};
                if (tx_ready_in) state_n = HDR1;
            end
            HDR1: begin
                tx_valid_out = 1'b1;
                tx_data_out  = {32'h0, addr};
                if (tx_ready_in) state_n = DATA;
            end
            DATA: begin
                tx_valid_out = f2cValid_in;
                f2cReady_out = tx_ready_in;
                tx_data_out  = f2cData_in;
                tx_eop_out   = f2cValid_in && (beat == LAST_BEAT);
                if (last_beat) state_n = (remaining > 8'd1) ? HDR0 : TOK0;
            end
            TOK0: begin
                tx_valid_out = 1'b1;
                tx_sop_out   = 1'b1;
                tx_data_out  = {req_id, 8'h00, 8'hFF, TOK_HDR};
                if (tx_ready_in) state_n = TOK1;
            end
            TOK1: begin
                tx_valid_out = 1'b1;
                tx_data_out  = {32'h0, base};
                if (tx_ready_in) state_n = TOKD;
            end
            TOKD: begin
                tx_valid_out = 1'b1;
                tx_eop_out   = 1'b1;
                tx_data_out  = TOKEN;
                if (tx_ready_in) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dma_write_engine.sv
// Bench for dma_write_engine: table + random DMA runs against a
// TLP-list reference model, plus reset-mid-packet and busy-write cases.
module tb_dma_write_engine;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [12:0] cfgBusDev_in;
    logic [6:0]  cpuChan_in;
    logic [31:0] cpuWrData_in;
    logic        cpuWrValid_in;
    logic [63:0] f2cData_in;
    logic        f2cValid_in;
    logic        f2cReady_out;
    logic [63:0] tx_data_out;
    logic        tx_valid_out;
    logic        tx_sop_out;
    logic        tx_eop_out;
    logic        tx_ready_in;
    logic        busy_out;
    logic [31:0] tlpCount_out;

    dma_write_engine dut (
        .clk_in(clk_in), .reset_in(reset_in), .cfgBusDev_in(cfgBusDev_in),
        .cpuChan_in(cpuChan_in), .cpuWrData_in(cpuWrData_in),
        .cpuWrValid_in(cpuWrValid_in), .f2cData_in(f2cData_in),
        .f2cValid_in(f2cValid_in), .f2cReady_out(f2cReady_out),
        .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out),
        .tx_sop_out(tx_sop_out), .tx_eop_out(tx_eop_out),
        .tx_ready_in(tx_ready_in), .busy_out(busy_out),
        .tlpCount_out(tlpCount_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [63:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct {
        logic [31:0] base_wr;
        logic [7:0]  count;
        logic [12:0] busdev;
        int          rdy_mode;
        bit          gaps;
        logic [31:0] exp_first_addr;
        int          exp_beats;
    } vec_t;

    localparam logic [63:0] TOKEN = 64'hCAFEF00DC0DEFACE;

    beat_t       expq[$];
    int          checks = 0;
    int          errors = 0;
    int          n_xfer;
    int          src_idx;
    int          rdy_mode;
    bit          gaps;
    bit          last_busy;
    bit          prev_stall;
    beat_t       prev_beat;
    logic [31:0] src_tag;
    logic [31:0] first_addr;
    logic [31:0] exp_tlps;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference: the full list of TLP beats a DMA must produce
    task automatic build(input logic [31:0] base, input int count,
                         input logic [12:0] busdev);
        logic [15:0] rid;
        logic [31:0] a;
        int          q;
        rid = {busdev, 3'b000};
        q = 0;
        for (int t = 0; t < count; t++) begin
            a = base + 32'd64 + 32'(t) * 32'd128;
            expq.push_back('{{rid, 8'h00, 8'hFF, 32'h40000020}, 1'b1, 1'b0});
            expq.push_back('{{32'h0, a}, 1'b0, 1'b0});
            for (int i = 0; i < 16; i++) begin
                expq.push_back('{{src_tag, 32'(q)}, 1'b0, i == 15});
                q++;
            end
        end
        expq.push_back('{{rid, 8'h00, 8'hFF, 32'h40000002}, 1'b1, 1'b0});
        expq.push_back('{{32'h0, base}, 1'b0, 1'b0});
        expq.push_back('{TOKEN, 1'b0, 1'b1});
    endtask

    task automatic cycle();
        bit    take;
        beat_t got, want;
        @(negedge clk_in);
        last_busy = busy_out;
        got = '{tx_data_out, tx_sop_out, tx_eop_out};
        if (tx_valid_out && tx_ready_in) begin
            n_xfer++;
            if (n_xfer == 2) first_addr = tx_data_out[31:0];
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_beat: got %h expected none", got);
            end else begin
                want = expq.pop_front();
                check($sformatf("beat%0d", n_xfer), {got.d[63:2], got.d[1:0]} ^ 64'(0)
                      , want.d);
                check($sformatf("beat%0d_sopeop", n_xfer),
                      64'({got.sop, got.eop}), 64'({want.sop, want.eop}));
            end
        end
        if (!tx_valid_out)
            check("sopeop_idle", 64'({tx_sop_out, tx_eop_out}), 64'd0);
        if (prev_stall && tx_valid_out)
            check("stall_stable", 64'(got ^ prev_beat), 64'd0);
        prev_stall = tx_valid_out && !tx_ready_in;
        prev_beat  = got;
        take = f2cValid_in && f2cReady_out;
        @(posedge clk_in);
        #1;
        if (take) src_idx++;
        f2cData_in  = {src_tag, 32'(src_idx)};
        f2cValid_in = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        unique case (rdy_mode)
            0: tx_ready_in = 1'b1;
            1: tx_ready_in = ~tx_ready_in;
            default: tx_ready_in = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic wr(input logic [6:0] chan, input logic [31:0] data);
        cpuChan_in    = chan;
        cpuWrData_in  = data;
        cpuWrValid_in = 1'b1;
        cycle();
        cpuWrValid_in = 1'b0;
    endtask

    task automatic run_dma(input vec_t v, input bit inject, input string tag);
        int busy_cycles;
        bit done;
        n_xfer       = 0;
        src_idx      = 0;
        src_tag      = $urandom;
        f2cData_in   = {src_tag, 32'd0};
        rdy_mode     = v.rdy_mode;
        gaps         = v.gaps;
        cfgBusDev_in = v.busdev;
        first_addr   = 'x;
        if (v.count != 0) begin
            build({v.base_wr[31:3], 3'b000}, int'(v.count), v.busdev);
            exp_tlps += 32'(v.count);
        end
        wr(7'd0, v.base_wr);
        wr(7'd1, {8'($urandom), 16'($urandom), v.count});
        busy_cycles = 0;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            cycle();
            if (!last_busy) done = 1'b1;
            else busy_cycles++;
            if (inject && busy_cycles == 5) begin
                cpuChan_in = 7'd1; cpuWrData_in = 32'd5; cpuWrValid_in = 1'b1;
            end else if (inject && busy_cycles == 6) begin
                cpuChan_in = 7'd0; cpuWrData_in = 32'h8000; cpuWrValid_in = 1'b1;
            end else begin
                cpuWrValid_in = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy expected idle", tag);
        end
        for (int c = 0; c < 3; c++) cycle();
        check({tag, "_pending"}, 64'(expq.size()), 64'd0);
        check({tag, "_nbeats"}, 64'(n_xfer), 64'(v.exp_beats));
        check({tag, "_tlpcount"}, 64'(tlpCount_out), 64'(exp_tlps));
        if (v.count != 0)
            check({tag, "_addr0"}, 64'(first_addr), 64'(v.exp_first_addr));
        if (v.rdy_mode == 0 && !v.gaps)
            check({tag, "_busycyc"}, 64'(busy_cycles), 64'(v.exp_beats));
        expq.delete();
    endtask

    vec_t vecs[7];
    vec_t rv;

    initial begin
        vecs[0] = '{32'h20,       8'd1, 13'h0008, 0, 1'b0, 32'h60,   21};
        vecs[1] = '{32'h1000,     8'd3, 13'h1ABC, 0, 1'b0, 32'h1040, 57};
        vecs[2] = '{32'h2000,     8'd2, 13'h0123, 1, 1'b1, 32'h2040, 39};
        vecs[3] = '{32'h27,       8'd1, 13'h0FFF, 2, 1'b1, 32'h60,   21};
        vecs[4] = '{32'hFFFFFFC0, 8'd2, 13'h0001, 1, 1'b0, 32'h0,    39};
        vecs[5] = '{32'h3000,     8'd0, 13'h0002, 0, 1'b0, 32'h0,    0};
        vecs[6] = '{32'h4000,     8'd2, 13'h0040, 0, 1'b0, 32'h4040, 39};

        reset_in      = 1'b1;
        cfgBusDev_in  = '0;
        cpuChan_in    = '0;
        cpuWrData_in  = '0;
        cpuWrValid_in = 1'b0;
        f2cData_in    = '0;
        f2cValid_in   = 1'b0;
        tx_ready_in   = 1'b1;
        rdy_mode      = 0;
        gaps          = 1'b0;
        prev_stall    = 1'b0;
        exp_tlps      = '0;
        src_tag       = '0;
        src_idx       = 0;
        n_xfer        = 0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_outs", {tx_data_out[63:2], tx_data_out[1:0] | {tx_valid_out, tx_sop_out}},
              64'd0);
        check("reset_flags", 64'({tx_eop_out, f2cReady_out, busy_out}), 64'd0);
        check("reset_count", 64'(tlpCount_out), 64'd0);
        @(negedge clk_in);
        reset_in = 1'b0;
        @(posedge clk_in);
        #1;

        for (int i = 0; i < 6; i++)
            run_dma(vecs[i], 1'b0, $sformatf("vec%0d", i));
        run_dma(vecs[6], 1'b1, "busywr");

        for (int i = 0; i < 4; i++) begin
            rv.base_wr  = $urandom;
            rv.count    = 8'($urandom_range(1, 4));
            rv.busdev   = 13'($urandom);
            rv.rdy_mode = $urandom_range(0, 2);
            rv.gaps     = 1'($urandom_range(0, 1));
            rv.exp_first_addr = {rv.base_wr[31:3], 3'b000} + 32'd64;
            rv.exp_beats = int'(rv.count) * 18 + 3;
            run_dma(rv, 1'b0, $sformatf("rnd%0d", i));
        end

        // Reset during DATA beat 7 of a single-TLP DMA
        n_xfer = 0; src_idx = 0; src_tag = 32'h0;
        f2cData_in = '0; rdy_mode = 0; gaps = 1'b0;
        cfgBusDev_in = 13'h0008;
        build(32'h20, 1, 13'h0008);
        wr(7'd0, 32'h20);
        wr(7'd1, 32'd1);
        for (int c = 0; c < 100 && n_xfer < 9; c++) cycle();
        check("rst_reach_beat7", 64'(n_xfer), 64'd9);
        #2;
        reset_in = 1'b1;
        #1;
        check("rst_async_outs", {tx_data_out[63:2], tx_data_out[1:0] | {tx_valid_out, tx_sop_out}},
              64'd0);
        check("rst_async_flags", 64'({tx_eop_out, f2cReady_out, busy_out}), 64'd0);
        check("rst_async_count", 64'(tlpCount_out), 64'd0);
        expq.delete();
        exp_tlps = '0;
        prev_stall = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b0;
        @(posedge clk_in);
        #1;
        run_dma(vecs[0], 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
